// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S transmitter.
package i2s_pkg;

    localparam int unsigned FRAME_BITS = 32;
    localparam int unsigned SLOT_BITS  = 16;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);

    typedef enum logic {IDLE, RUN} i2s_state_t;

    typedef logic signed [15:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } i2s_pair_t;

    // Word select for the bit about to be driven; leads the slot MSB by one BCLK.
    function automatic logic lr_for_bit(input logic [BIT_W-1:0] b);
        return (b >= BIT_W'(SLOT_BITS - 1)) && (b <= BIT_W'(FRAME_BITS - 2));
    endfunction

endpackage

// File: rtl/i2s_clk_div.sv
// BCLK generator: toggles bclk every BCLK_DIV enabled cycles and flags each edge
// with a combinational strobe aligned to the clk edge that moves bclk.
module i2s_clk_div #(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic bclk,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned CNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BCLK_DIV - 1);

    logic [CNT_W-1:0] divcnt;
    logic             wrap_c;

    assign wrap_c = enable && (divcnt == LAST);
    assign rise_c = wrap_c && !bclk;
    assign fall_c = wrap_c && bclk;

    always_ff @(posedge clk) begin
        if (!reset_n || !enable) begin
            divcnt <= '0;
            bclk   <= 1'b0;
        end else if (wrap_c) begin
            divcnt <= '0;
            bclk   <= ~bclk;
        end else begin
            divcnt <= divcnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-deep holding register feeding a 32-bit frame shifter.
// Optional I2S_TX_MUTE_ON_UNDERRUN_EN sends silence on underrun instead of repeating.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] left_in,
    input  logic [15:0] right_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        underrun
);

    i2s_state_t              state;
    logic [BIT_W-1:0]        bitcnt;
    i2s_pair_t               hold_reg;
    logic                    holding_full;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic [FRAME_BITS-1:0]   last_frame;

    logic                    fall_c;
    logic                    unused_rise_c;
    logic                    accept_c;
    logic                    boundary_c;
    logic                    full_next_c;
    logic [FRAME_BITS-1:0]   load_word_c;

    i2s_clk_div #(.BCLK_DIV(BCLK_DIV)) u_clk_div (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (state == RUN),
        .bclk    (bclk),
        .rise_c  (unused_rise_c),
        .fall_c  (fall_c)
    );

    assign accept_c    = sample_valid && sample_ready;
    assign boundary_c  = fall_c && (bitcnt == BIT_W'(FRAME_BITS - 1));
    assign full_next_c = (holding_full && !boundary_c) || accept_c;

    // Word loaded at a frame boundary: fresh pair, or the underrun fill.
    always_comb begin
        load_word_c = FRAME_BITS'(hold_reg);
        if (!holding_full) begin
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
            load_word_c = '0;
`else
            load_word_c = last_frame;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            bitcnt       <= BIT_W'(FRAME_BITS - 1);
            hold_reg     <= '0;
            holding_full <= 1'b0;
            shift_reg    <= '0;
            last_frame   <= '0;
            lrclk        <= 1'b0;
            sdata        <= 1'b0;
            underrun     <= 1'b0;
            sample_ready <= 1'b1;
        end else begin
            underrun <= 1'b0;
            if (state == IDLE && accept_c) begin
                state <= RUN;
            end
            // All serial outputs move together on the falling BCLK.
            if (fall_c) begin
                bitcnt <= bitcnt + BIT_W'(1);
                lrclk  <= lr_for_bit(bitcnt + BIT_W'(1));
                if (boundary_c) begin
                    sdata     <= load_word_c[FRAME_BITS-1];
                    shift_reg <= {load_word_c[FRAME_BITS-2:0], 1'b0};
                    if (holding_full) begin
                        last_frame <= FRAME_BITS'(hold_reg);
                    end else begin
                        underrun <= 1'b1;
                    end
                end else begin
                    sdata     <= shift_reg[FRAME_BITS-1];
                    shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                end
            end
            if (accept_c) begin
                hold_reg <= i2s_pair_t'({left_in, right_in});
            end
            holding_full <= full_next_c;
            sample_ready <= ~full_next_c;
        end
    end

endmodule
